// File: rtl/front_end_pipe_ctrl.sv
// Front-end pipeline controller: IF/ID/DP stall and kill sequencing for dispatch back-pressure,
// mispredict flush/recovery and illegal-instruction traps. `FE_PIPE_CTRL_PERF_EN adds perf counters.
module front_end_pipe_ctrl #(
  parameter int NUM_RS         = 5,
  parameter int RS_ENT_W       = 3,
  parameter int RECOVER_CYCLES = 2,
  parameter int ADDR_W         = 32
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                id_valid_i,
  input  logic                id_illegal_i,
  input  logic [RS_ENT_W-1:0] rs_ent_id_i,
  input  logic [NUM_RS-1:0]   rs_full_i,
  input  logic                rob_full_i,
  input  logic                rob_empty_i,
  input  logic                mispred_i,
  input  logic [ADDR_W-1:0]   mispred_pc_i,
  input  logic [ADDR_W-1:0]   trap_vec_i,
  input  logic                trap_ack_i,
  output logic                stall_IF_o,
  output logic                stall_ID_o,
  output logic                stall_DP_o,
  output logic                kill_IF_o,
  output logic                kill_ID_o,
  output logic                kill_DP_o,
  output logic                redirect_o,
  output logic [ADDR_W-1:0]   redirect_pc_o,
  output logic                trap_req_o,
`ifdef FE_PIPE_CTRL_PERF_EN
  output logic [31:0]         stall_cnt_o,
  output logic [31:0]         flush_cnt_o,
`endif
  output logic                ctrl_busy_o
);

  localparam logic [2:0] RUN     = 3'd0;
  localparam logic [2:0] FLUSH   = 3'd1;
  localparam logic [2:0] RECOVER = 3'd2;
  localparam logic [2:0] DRAIN   = 3'd3;
  localparam logic [2:0] TRAP    = 3'd4;

  // Counter holds remaining RECOVER cycles minus one, so cnt==0 marks the last stall cycle.
  localparam logic [3:0] RC_LOAD = (RECOVER_CYCLES > 0) ? 4'(RECOVER_CYCLES - 1) : 4'd0;

  logic [2:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              rs_hit, dp_stall, hold;

  always_comb begin
    rs_hit = 1'b0;
    for (int i = 0; i < NUM_RS; i++)
      if (rs_ent_id_i == RS_ENT_W'(i)) rs_hit = rs_full_i[i];
  end

  assign dp_stall = id_valid_i & (rob_full_i | rs_hit);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    if (mispred_i) begin
      state_d = FLUSH;
      pc_d    = mispred_pc_i;
    end else begin
      case (state_q)
        RUN:     if (id_valid_i && id_illegal_i) state_d = DRAIN;
        FLUSH: begin
          if (RECOVER_CYCLES == 0) state_d = RUN;
          else begin
            state_d = RECOVER;
            cnt_d   = RC_LOAD;
          end
        end
        RECOVER: begin
          if (cnt_q == 4'd0) state_d = RUN;
          else               cnt_d   = cnt_q - 4'd1;
        end
        DRAIN:   if (rob_empty_i) state_d = TRAP;
        TRAP: begin
          if (trap_ack_i) begin
            state_d = FLUSH;
            pc_d    = trap_vec_i;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  end

  // Back-pressure path is combinational; gate it so every output reads 0 while in reset.
  assign hold = (state_q == RECOVER) | (state_q == DRAIN) | (state_q == TRAP) |
                ((state_q == RUN) & dp_stall & reset_n_i);

  assign stall_IF_o    = hold;
  assign stall_ID_o    = hold;
  assign stall_DP_o    = hold;
  assign kill_IF_o     = (state_q == FLUSH);
  assign kill_ID_o     = (state_q == FLUSH);
  assign kill_DP_o     = (state_q == FLUSH);
  assign redirect_o    = (state_q == FLUSH);
  assign redirect_pc_o = pc_q;
  assign trap_req_o    = (state_q == TRAP);
  assign ctrl_busy_o   = (state_q != RUN);

`ifdef FE_PIPE_CTRL_PERF_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_DP_o && stall_cnt_o != 32'hFFFF_FFFF) stall_cnt_o <= stall_cnt_o + 32'd1;
      if (state_d == FLUSH && flush_cnt_o != 32'hFFFF_FFFF) flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_front_end_pipe_ctrl.sv
// Bench for front_end_pipe_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_front_end_pipe_ctrl;
  localparam int NUM_RS = 5, RS_ENT_W = 3, RC = 2, ADDR_W = 32;

  logic clk, reset_n;
  logic id_valid, id_illegal, rob_full, rob_empty, mispred, trap_ack;
  logic [RS_ENT_W-1:0] rs_ent;
  logic [NUM_RS-1:0]   rs_full;
  logic [ADDR_W-1:0]   mispred_pc, trap_vec;
  logic stall_IF, stall_ID, stall_DP, kill_IF, kill_ID, kill_DP, redirect, trap_req, busy;
  logic [ADDR_W-1:0] redirect_pc;
`ifdef FE_PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int checks = 0, failures = 0;

  front_end_pipe_ctrl #(.NUM_RS(NUM_RS), .RS_ENT_W(RS_ENT_W), .RECOVER_CYCLES(RC), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .id_valid_i(id_valid), .id_illegal_i(id_illegal),
    .rs_ent_id_i(rs_ent), .rs_full_i(rs_full), .rob_full_i(rob_full), .rob_empty_i(rob_empty),
    .mispred_i(mispred), .mispred_pc_i(mispred_pc), .trap_vec_i(trap_vec), .trap_ack_i(trap_ack),
    .stall_IF_o(stall_IF), .stall_ID_o(stall_ID), .stall_DP_o(stall_DP),
    .kill_IF_o(kill_IF), .kill_ID_o(kill_ID), .kill_DP_o(kill_DP),
    .redirect_o(redirect), .redirect_pc_o(redirect_pc), .trap_req_o(trap_req),
`ifdef FE_PIPE_CTRL_PERF_EN
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt),
`endif
    .ctrl_busy_o(busy));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pending flush pulse, stall cycles left, waiting-for-empty, trap pending.
  bit m_flush, m_drain, m_trap;
  int m_rec_left;
  logic [ADDR_W-1:0] m_pc;
  int m_stalls, m_flushes;
  logic exp_stall, exp_busy, rs_is_full;
  logic [NUM_RS-1:0] rs_sh;

  always_comb begin
    rs_sh      = rs_full >> rs_ent;
    rs_is_full = (int'(rs_ent) < NUM_RS) ? rs_sh[0] : 1'b0;
    exp_busy   = m_flush | (m_rec_left > 0) | m_drain | m_trap;
    exp_stall  = (m_rec_left > 0) | m_drain | m_trap |
                 (!exp_busy & reset_n & id_valid & (rob_full | rs_is_full));
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_flush <= 0; m_drain <= 0; m_trap <= 0; m_rec_left <= 0; m_pc <= '0;
      m_stalls <= 0; m_flushes <= 0;
    end else begin
      if (exp_stall) m_stalls <= m_stalls + 1;
      if (mispred) begin
        m_flush <= 1; m_rec_left <= 0; m_drain <= 0; m_trap <= 0;
        m_pc <= mispred_pc; m_flushes <= m_flushes + 1;
      end else if (m_flush) begin
        m_flush <= 0; m_rec_left <= RC;
      end else if (m_rec_left > 0) begin
        m_rec_left <= m_rec_left - 1;
      end else if (m_drain) begin
        if (rob_empty) begin m_drain <= 0; m_trap <= 1; end
      end else if (m_trap) begin
        if (trap_ack) begin
          m_trap <= 0; m_flush <= 1; m_pc <= trap_vec; m_flushes <= m_flushes + 1;
        end
      end else if (id_valid && id_illegal) begin
        m_drain <= 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("stall_IF", stall_IF, exp_stall);
    chk("stall_ID", stall_ID, exp_stall);
    chk("stall_DP", stall_DP, exp_stall);
    chk("kill_IF", kill_IF, m_flush);
    chk("kill_ID", kill_ID, m_flush);
    chk("kill_DP", kill_DP, m_flush);
    chk("redirect", redirect, m_flush);
    chk("redirect_pc", redirect_pc, m_pc);
    chk("trap_req", trap_req, m_trap);
    chk("ctrl_busy", busy, exp_busy);
`ifdef FE_PIPE_CTRL_PERF_EN
    chk("stall_cnt", stall_cnt, m_stalls);
    chk("flush_cnt", flush_cnt, m_flushes);
`endif
  end

  task automatic idle();
    id_valid = 0; id_illegal = 0; rs_ent = '0; rs_full = '0; rob_full = 0; rob_empty = 0;
    mispred = 0; mispred_pc = '0; trap_vec = '0; trap_ack = 0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic chk_out(input string name, input logic st, input logic kl, input logic bz);
    @(negedge clk);
    chk({name, "_stall"}, stall_DP, st);
    chk({name, "_kill"}, kill_DP, kl);
    chk({name, "_busy"}, busy, bz);
  endtask

  initial begin
    reset_n = 0;
    idle();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_pc", redirect_pc, 0);
    cyc(); reset_n = 1;

    // T1: RS 2 full -> back-pressure stall
    id_valid = 1; rs_ent = 3'd2; rs_full = 5'b00100;
    for (int i = 0; i < 3; i++) begin chk_out("t1", 1, 0, 0); cyc(); end
    rs_ent = 3'd6; rs_full = 5'b11111;
    chk_out("t1_oob", 0, 0, 0); cyc();
    rs_ent = 3'd1; rs_full = 5'b11101; rob_full = 1;
    chk_out("t1_rob", 1, 0, 0); cyc();
    idle();

    // T2: mispredict flush then 2 recovery stall cycles
    mispred = 1; mispred_pc = 32'h8000_0040;
    chk_out("t2_run", 0, 0, 0); cyc(); idle();
    chk_out("t2_flush", 0, 1, 1);
    chk("t2_redirect", redirect, 1);
    chk("t2_pc", redirect_pc, 32'h8000_0040);
    cyc(); chk_out("t2_rec0", 1, 0, 1);
    cyc(); chk_out("t2_rec1", 1, 0, 1);
    cyc(); chk_out("t2_run2", 0, 0, 0);

    // T3: illegal -> drain -> trap -> flush to trap vector
    id_valid = 1; id_illegal = 1;
    cyc();
    for (int i = 0; i < 4; i++) begin chk_out("t3_drain", 1, 0, 1); chk("t3_noreq", trap_req, 0); cyc(); end
    rob_empty = 1; cyc();
    chk_out("t3_trap", 1, 0, 1); chk("t3_req", trap_req, 1);
    id_valid = 0; id_illegal = 0; trap_ack = 1; trap_vec = 32'h0000_0100;
    cyc(); idle();
    chk_out("t3_flush", 0, 1, 1);
    chk("t3_pc", redirect_pc, 32'h100); chk("t3_req_drop", trap_req, 0);
    repeat (3) cyc();

    // T4: mispredict beats trap_ack in TRAP
    id_valid = 1; id_illegal = 1; rob_empty = 1;
    cyc(); cyc(); idle();
    mispred = 1; mispred_pc = 32'h200; trap_ack = 1; trap_vec = 32'h400;
    @(negedge clk); chk("t4_req", trap_req, 1);
    cyc(); idle();
    chk_out("t4_flush", 0, 1, 1);
    chk("t4_pc", redirect_pc, 32'h200); chk("t4_req_drop", trap_req, 0);
    repeat (3) cyc();

    // T5: second mispredict during first recovery cycle restarts the flush
    mispred = 1; mispred_pc = 32'h1000;
    cyc(); idle(); cyc();
    mispred = 1; mispred_pc = 32'h300;
    chk_out("t5_rec", 1, 0, 1);
    cyc(); idle();
    chk_out("t5_flush", 0, 1, 1); chk("t5_pc", redirect_pc, 32'h300);
    cyc(); chk_out("t5_rec0", 1, 0, 1);
    cyc(); chk_out("t5_rec1", 1, 0, 1);
    cyc(); chk_out("t5_run", 0, 0, 0);

    // T6: async reset mid-drain
    id_valid = 1; id_illegal = 1; rob_full = 1;
    cyc(); chk_out("t6_drain", 1, 0, 1);
    #2 reset_n = 0;
    #1;
    chk("t6_stall", stall_DP, 0); chk("t6_busy", busy, 0); chk("t6_trap", trap_req, 0);
    chk("t6_redir", redirect, 0); chk("t6_pc", redirect_pc, 0);
`ifdef FE_PIPE_CTRL_PERF_EN
    chk("t6_scnt", stall_cnt, 0); chk("t6_fcnt", flush_cnt, 0);
`endif
    idle();
    cyc(); reset_n = 1;
    chk_out("t6_run", 0, 0, 0);

    // Randomized traffic, checked by the per-cycle compare process
    for (int n = 0; n < 3000; n++) begin
      cyc();
      reset_n    = ($urandom_range(499) != 0);
      id_valid   = ($urandom_range(1) == 1);
      id_illegal = ($urandom_range(7) == 0);
      rs_ent     = RS_ENT_W'($urandom_range(7));
      rs_full    = NUM_RS'($urandom);
      rob_full   = ($urandom_range(5) == 0);
      rob_empty  = ($urandom_range(2) == 0);
      mispred    = ($urandom_range(19) == 0);
      mispred_pc = $urandom;
      trap_vec   = $urandom;
      trap_ack   = ($urandom_range(3) == 0);
    end
    cyc(); reset_n = 1; idle();
    repeat (4) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
